sand_fetch: RTL and testbench
=============================

SAND_FETCH -- requirements
Module: sand_fetch

Interface
REQ-001 Parameter: WORDS_PER_ROW, default 80, number of 16-bit memory words per cell row (8 two-bit cells per word).
REQ-002 Parameter: ROWS, default 480, number of cell rows in the screen buffer.
REQ-003 Port: clock  in  1  sole clock; all logic is clocked on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: screen_ptr  in  32  screen buffer base word address; bits [23:0] are used.
REQ-006 Port: start  in  1  one-cycle pulse that begins a frame scan.
REQ-007 Port: mem_address  out  24  Avalon-MM word address.
REQ-008 Port: mem_read  out  1  Avalon-MM read request.
REQ-009 Port: mem_waitrequest  in  1  Avalon-MM stall.
REQ-010 Port: mem_readdatavalid  in  1  Avalon-MM read data strobe.
REQ-011 Port: mem_readdata  in  16  Avalon-MM read data.
REQ-012 Port: region  out  16  word at the current position (8 cells).
REQ-013 Port: floor  out  16  word directly below the current position.
REQ-014 Port: region_x  out  16  current word column; region_y  out  16  current row.
REQ-015 Port: region_valid  out  1  region/floor/region_x/region_y valid; region_ready  in  1  downstream accepts.
REQ-016 Port: busy  out  1  frame scan in progress; frame_done  out  1  one-cycle pulse when the scan completes.

Function
REQ-017 States: IDLE, REQ_REG, WAIT_REG, REQ_FLR, WAIT_FLR, PRESENT.
REQ-018 IDLE: on start, latch row_base = screen_ptr[23:0] + (ROWS-1)*WORDS_PER_ROW mod 2^24, x=0, y=ROWS-1, set busy, go to REQ_REG; start in any other state is ignored.
REQ-019 Scan order: rows bottom to top (y = ROWS-1 down to 0), columns left to right within a row (x = 0 up to WORDS_PER_ROW-1).
REQ-020 REQ_REG: mem_read=1, mem_address=row_base+x; both held stable while mem_waitrequest=1; on the cycle mem_waitrequest=0, go to WAIT_REG and drop mem_read on the next cycle.
REQ-021 WAIT_REG: on mem_readdatavalid, latch mem_readdata into region; if y=ROWS-1, load floor=16'hFFFF (wall row) and go to PRESENT, else go to REQ_FLR.
REQ-022 REQ_FLR: same handshake as REQ_REG with mem_address=row_base+WORDS_PER_ROW+x; WAIT_FLR latches floor, then goes to PRESENT.
REQ-023 Only one read is outstanding at any time; mem_read is 0 in IDLE, WAIT_*, and PRESENT.
REQ-024 mem_readdatavalid outside WAIT_REG/WAIT_FLR is ignored.
REQ-025 PRESENT: region_valid=1 with all outputs stable until region_ready=1; transfer completes on the cycle valid and ready are both 1.
REQ-026 On transfer: if x<WORDS_PER_ROW-1, x+=1; else x=0, y-=1, row_base-=WORDS_PER_ROW; go to REQ_REG.
REQ-027 Transfer at x=WORDS_PER_ROW-1, y=0: frame_done=1 for exactly the next cycle, busy=0, go to IDLE.
REQ-028 All address arithmetic is 24-bit modulo 2^24 (wraps, no saturation); no multiplier is used after the start latch.
REQ-029 region_valid is registered; region_ready has no combinational path to mem_read or mem_address.

Reset
REQ-030 While reset=1: state=IDLE, mem_read=0, mem_address=0, region=0, floor=0, region_x=0, region_y=0, region_valid=0, busy=0, frame_done=0.
REQ-031 Reset asserted mid-scan (including while a read is outstanding) aborts the scan; mem_read drops the next cycle; a late mem_readdatavalid after reset is ignored.
REQ-032 After reset, a new start is required to begin a scan.

Verification
REQ-033 WORDS_PER_ROW=2, ROWS=2, screen_ptr=0x100, no stall, ready=1: reads in order 0x102, 0x103, 0x100, 0x102, 0x101, 0x103; outputs (x,y)=(0,1),(1,1),(0,0),(1,0); floor=FFFF for y=1; single frame_done.
REQ-034 mem_waitrequest=1 for 3 cycles on the first read: mem_read and mem_address held constant for 4 cycles; exactly one read is accepted.
REQ-035 region_ready=0 for 5 cycles in PRESENT: region_valid stays 1, outputs stable, no new mem_read until ready=1.
REQ-036 screen_ptr=0xFFFFFF, WORDS_PER_ROW=2, ROWS=2: first address 0x000001 (wrap).
REQ-037 reset pulsed during WAIT_FLR, then readdatavalid=1: all outputs at reset values, state IDLE, no region_valid.
REQ-038 start pulsed while busy: ignored; the scan finishes with one frame_done and the expected address sequence.

Source files
------------

// File: rtl/sand_fetch.sv
// Frame scanner for a 2-bit-cell sand screen: walks the buffer bottom row first,
// fetching each word plus the word below it, and presents both downstream.
module sand_fetch #(
  parameter int WORDS_PER_ROW = 80,
  parameter int ROWS          = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] screen_ptr,
  input  logic        start,
  output logic [23:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [15:0] mem_readdata,
  output logic [15:0] region,
  output logic [15:0] floor,
  output logic [15:0] region_x,
  output logic [15:0] region_y,
  output logic        region_valid,
  input  logic        region_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [23:0] ROW_W        = 24'(WORDS_PER_ROW);
  localparam logic [23:0] LAST_ROW_OFS = 24'((ROWS - 1) * WORDS_PER_ROW);
  localparam logic [15:0] X_LAST       = 16'(WORDS_PER_ROW - 1);
  localparam logic [15:0] Y_TOP        = 16'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, REQ_REG, WAIT_REG, REQ_FLR, WAIT_FLR, PRESENT
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] row_base;
  logic [15:0] x, y;
  logic        xfer, last_xfer, top_row, last_col;
  logic        unused_ptr_hi;

  assign unused_ptr_hi = ^screen_ptr[31:24];

  assign top_row   = (y == Y_TOP);
  assign last_col  = (x == X_LAST);
  assign xfer      = (state == PRESENT) && region_ready;
  assign last_xfer = xfer && last_col && (y == 16'd0);

  assign region_x  = x;
  assign region_y  = y;

  // Bus outputs decode from registered state only, so region_ready never reaches them.
  always_comb begin
    state_nxt   = state;
    mem_read    = 1'b0;
    mem_address = '0;
    case (state)
      IDLE:     if (start) state_nxt = REQ_REG;
      REQ_REG: begin
        mem_read    = 1'b1;
        mem_address = row_base + {8'd0, x};
        if (!mem_waitrequest) state_nxt = WAIT_REG;
      end
      WAIT_REG: if (mem_readdatavalid) state_nxt = top_row ? PRESENT : REQ_FLR;
      REQ_FLR: begin
        mem_read    = 1'b1;
        mem_address = row_base + ROW_W + {8'd0, x};
        if (!mem_waitrequest) state_nxt = WAIT_FLR;
      end
      WAIT_FLR: if (mem_readdatavalid) state_nxt = PRESENT;
      PRESENT:  if (region_ready) state_nxt = last_xfer ? IDLE : REQ_REG;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      row_base     <= '0;
      x            <= '0;
      y            <= '0;
      region       <= '0;
      floor        <= '0;
      region_valid <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      region_valid <= (state_nxt == PRESENT);
      frame_done   <= last_xfer;
      case (state)
        IDLE: if (start) begin
          row_base <= screen_ptr[23:0] + LAST_ROW_OFS;
          x        <= '0;
          y        <= Y_TOP;
          busy     <= 1'b1;
        end
        WAIT_REG: if (mem_readdatavalid) begin
          region <= mem_readdata;
          // Nothing lies below the bottom row: treat it as solid wall.
          if (top_row) floor <= 16'hFFFF;
        end
        WAIT_FLR: if (mem_readdatavalid) floor <= mem_readdata;
        PRESENT: if (region_ready) begin
          if (last_xfer) begin
            busy <= 1'b0;
          end else if (!last_col) begin
            x <= x + 16'd1;
          end else begin
            x        <= '0;
            y        <= y - 16'd1;
            row_base <= row_base - ROW_W;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sand_fetch.sv
// Randomized bench for sand_fetch: Avalon slave model with random stalls/latency,
// random downstream backpressure, and a pointer-arithmetic reference of the frame scan.
module tb_sand_fetch;
  localparam int W = 2;
  localparam int R = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] screen_ptr = '0;
  logic        start = 1'b0;
  logic [23:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest = 1'b0;
  logic        mem_readdatavalid = 1'b0;
  logic [15:0] mem_readdata = '0;
  logic [15:0] region, floor, region_x, region_y;
  logic        region_valid;
  logic        region_ready = 1'b0;
  logic        busy, frame_done;

  always #5 clock = ~clock;

  sand_fetch #(.WORDS_PER_ROW(W), .ROWS(R)) dut (
    .clock(clock), .reset(reset), .screen_ptr(screen_ptr), .start(start),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata(mem_readdata), .region(region), .floor(floor),
    .region_x(region_x), .region_y(region_y), .region_valid(region_valid),
    .region_ready(region_ready), .busy(busy), .frame_done(frame_done)
  );

  typedef struct { logic [23:0] addr; bit flr; } rd_t;
  typedef struct { logic [15:0] region, floor, x, y; } xf_t;

  rd_t rd_q[$];
  xf_t xf_q[$];
  int  n_vec = 0, n_bad = 0;

  int stall_pct, ready_pct, spur_pct, stall_first, hold_ready, lat_min;
  bit kick;
  logic [23:0] kick_ptr, out_addr, prev_addr, first_addr;
  bit outst, exp_busy, exp_fd, prev_stall, prev_hold, got_flr;
  int lat, n_rd, exp_rd;
  logic [15:0] prev_reg, prev_flr, prev_x, prev_y;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] memdata(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'h3C5A;
  endfunction

  // Cell word (x,y) lives at ptr + y*W + x; its floor is the same column one row down.
  function automatic void plan(input logic [23:0] p);
    for (int yy = R - 1; yy >= 0; yy--)
      for (int xx = 0; xx < W; xx++) begin
        logic [23:0] ra, fa;
        xf_t e;
        ra = p + 24'(yy * W + xx);
        fa = p + 24'((yy + 1) * W + xx);
        rd_q.push_back('{ra, 1'b0});
        e.region = memdata(ra);
        e.x = 16'(xx);
        e.y = 16'(yy);
        if (yy == R - 1) e.floor = 16'hFFFF;
        else begin
          rd_q.push_back('{fa, 1'b1});
          e.floor = memdata(fa);
        end
        xf_q.push_back(e);
      end
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_read"}, 32'(mem_read), 0);
    chk({tag, "_mem_address"}, 32'(mem_address), 0);
    chk({tag, "_region"}, 32'(region), 0);
    chk({tag, "_floor"}, 32'(floor), 0);
    chk({tag, "_region_x"}, 32'(region_x), 0);
    chk({tag, "_region_y"}, 32'(region_y), 0);
    chk({tag, "_region_valid"}, 32'(region_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  task automatic clear_model();
    rd_q.delete();
    xf_q.delete();
    outst = 0; exp_busy = 0; exp_fd = 0; prev_stall = 0; prev_hold = 0; kick = 0;
  endtask

  // One clock: called at a falling edge, checks what the DUT shows, drives the next inputs.
  task automatic step();
    bit acc, xf, nxt_busy, nxt_fd;
    xf_t e;
    rd_t r;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    if (outst) chk("rd_while_outstanding", 32'(mem_read), 0);
    if (region_valid) chk("rd_in_present", 32'(mem_read), 0);
    if (prev_stall) begin
      chk("rd_hold", 32'(mem_read), 1);
      chk("addr_hold", 32'(mem_address), 32'(prev_addr));
    end
    if (prev_hold) begin
      chk("valid_hold", 32'(region_valid), 1);
      chk("region_hold", 32'(region), 32'(prev_reg));
      chk("floor_hold", 32'(floor), 32'(prev_flr));
      chk("x_hold", 32'(region_x), 32'(prev_x));
      chk("y_hold", 32'(region_y), 32'(prev_y));
    end
    nxt_busy = exp_busy; nxt_fd = 0; got_flr = 0;

    mem_readdatavalid = 1'b0;
    mem_readdata = 16'($urandom);
    if (outst) begin
      if (lat == 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata = memdata(out_addr);
        outst = 0;
      end else lat--;
    end else if ($urandom_range(99) < spur_pct) mem_readdatavalid = 1'b1;

    if (mem_read && stall_first > 0) begin
      mem_waitrequest = 1'b1;
      stall_first--;
    end else mem_waitrequest = ($urandom_range(99) < stall_pct);
    acc = mem_read && !mem_waitrequest;
    if (acc) begin
      if (rd_q.size() == 0) chk("rd_extra", 32'(mem_read), 0);
      else begin
        r = rd_q.pop_front();
        chk("rd_addr", 32'(mem_address), 32'(r.addr));
        if (n_rd == 0) first_addr = mem_address;
        n_rd++;
        got_flr = r.flr;
      end
      outst = 1;
      lat = int'($urandom_range(lat_min + 3, lat_min));
      out_addr = mem_address;
    end

    if (region_valid && hold_ready > 0) begin
      region_ready = 1'b0;
      hold_ready--;
    end else region_ready = ($urandom_range(99) < ready_pct);
    xf = region_valid && region_ready;
    if (xf) begin
      if (xf_q.size() == 0) chk("xfer_extra", 32'(region_valid), 0);
      else begin
        e = xf_q.pop_front();
        chk("region", 32'(region), 32'(e.region));
        chk("floor", 32'(floor), 32'(e.floor));
        chk("region_x", 32'(region_x), 32'(e.x));
        chk("region_y", 32'(region_y), 32'(e.y));
        if (xf_q.size() == 0) begin nxt_fd = 1; nxt_busy = 0; end
      end
    end

    start = 1'b0;
    if (kick) begin
      start = 1'b1;
      screen_ptr = {8'($urandom), kick_ptr};
      plan(kick_ptr);
      exp_rd = rd_q.size();
      n_rd = 0;
      nxt_busy = 1;
      kick = 0;
    end else if (exp_busy && $urandom_range(99) < 5) begin
      start = 1'b1;
      screen_ptr = $urandom;
    end

    prev_stall = mem_read && mem_waitrequest;
    prev_addr  = mem_address;
    prev_hold  = region_valid && !region_ready;
    prev_reg = region; prev_flr = floor; prev_x = region_x; prev_y = region_y;
    exp_busy = nxt_busy;
    exp_fd   = nxt_fd;
    @(negedge clock);
  endtask

  task automatic run_frame(input logic [23:0] p, input int sp, input int rp, input int spp,
                           input int sf, input int hr, input int lm);
    int cyc;
    cyc = 0;
    stall_pct = sp; ready_pct = rp; spur_pct = spp;
    stall_first = sf; hold_ready = hr; lat_min = lm;
    kick = 1; kick_ptr = p;
    step();
    while ((exp_busy || exp_fd) && cyc < 2000) begin
      step();
      cyc++;
    end
    chk("frame_timeout", 32'(cyc >= 2000), 0);
    chk("rd_count", 32'(n_rd), 32'(exp_rd));
    chk("xfer_left", 32'(xf_q.size()), 0);
    if (cyc >= 2000) begin
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      clear_model();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    clear_model();
    n_rd = 0; exp_rd = 0; first_addr = '0; lat = 0;
    repeat (2) @(negedge clock);
    chk_reset("reset");
    reset = 1'b0;

    // Plain scan: expected order 102,103,100,102,101,103.
    run_frame(24'h000100, 0, 100, 0, 0, 0, 0);
    chk("first_addr_0x100", 32'(first_addr), 32'h102);
    // First read stalled for three cycles.
    run_frame(24'h000100, 0, 100, 0, 3, 0, 0);
    // Downstream holds off for five cycles.
    run_frame(24'h000200, 0, 100, 0, 0, 5, 1);
    // Base pointer wraps past 2^24.
    run_frame(24'hFFFFFF, 0, 100, 0, 0, 0, 0);
    chk("first_addr_wrap", 32'(first_addr), 32'h000001);

    // Abort while a floor read is outstanding, then deliver a stale response.
    stall_pct = 0; ready_pct = 100; spur_pct = 0; stall_first = 0; hold_ready = 0; lat_min = 4;
    kick = 1; kick_ptr = 24'h004000; cyc = 0;
    step();
    while (!got_flr && cyc < 200) begin step(); cyc++; end
    chk("floor_read_reached", 32'(got_flr), 1);
    reset = 1'b1; start = 1'b0; mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0;
    @(negedge clock);
    chk_reset("midscan_reset");
    reset = 1'b0; mem_readdatavalid = 1'b1; mem_readdata = 16'hBEEF;
    @(negedge clock);
    mem_readdatavalid = 1'b0;
    clear_model();
    repeat (6) begin
      chk("post_reset_valid", 32'(region_valid), 0);
      chk("post_reset_rd", 32'(mem_read), 0);
      chk("post_reset_busy", 32'(busy), 0);
      chk("post_reset_region", 32'(region), 0);
      chk("post_reset_floor", 32'(floor), 0);
      @(negedge clock);
    end

    for (int i = 0; i < 20; i++)
      run_frame((i % 4 == 0) ? 24'hFFFFFF - 24'($urandom_range(5, 0)) : 24'($urandom),
                int'($urandom_range(50, 0)), int'($urandom_range(100, 30)),
                int'($urandom_range(30, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(6, 0)), int'($urandom_range(2, 0)));

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
